// File: rtl/posit_pkg.sv
// +------------------------------------------------------------------+
// | posit_pkg: shared posit<32,2> widths and unpacked-field record.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package posit_pkg;
    localparam int N  = 32;
    localparam int ES = 2;
    localparam int SW = 8;
    localparam int FW = N - ES - 2;

    typedef struct packed {
        logic          sign;
        logic [SW-1:0] scale;
        logic [FW-1:0] frac;
        logic          zero;
        logic          inf;
    } posit_unpacked_t;
endpackage

`default_nettype wire

// File: rtl/posit_lzc.sv
// +------------------------------------------------------------------+
// | posit_lzc: combinational leading-run counter (run of MSB value). |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module posit_lzc #(
    parameter int W  = 31,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x_i,
    output logic [CW-1:0] cnt_o,
    output logic          bit_o
);
    logic [CW-1:0] cnt;
    logic          run;

    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (run && (x_i[i] == x_i[W-1])) begin
                cnt = cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign cnt_o = cnt;
    assign bit_o = x_i[W-1];
endmodule

`default_nettype wire

// File: rtl/posit_extract.sv
// +------------------------------------------------------------------+
// | posit_extract: 3-stage posit<32,2> unpacker (sign/scale/frac).   |
// | Option POSIT_EXTRACT_OUTREG_EN adds an output flop stage (lat 4).|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module posit_extract #(
    parameter int N  = posit_pkg::N,
    parameter int ES = posit_pkg::ES,
    parameter int SW = posit_pkg::SW,
    parameter int FW = posit_pkg::FW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_i,
    input  logic          start_i,
    output logic          sign_o,
    output logic [SW-1:0] scale_o,
    output logic [FW-1:0] frac_o,
    output logic          zero_o,
    output logic          inf_o,
    output logic          done_o
);
    import posit_pkg::*;

    localparam int CW = $clog2(N);
    localparam int KW = SW - ES;
    localparam int RW = ES + FW - 1;

    logic            s1_vld_q, s1_sign_q, s1_zero_q, s1_inf_q;
    logic [N-2:0]    s1_mag_q, s1_mag_d;
    logic [CW-1:0]   lzc_cnt;
    logic            lzc_bit;
    logic [KW-1:0]   cnt_ext;
    logic            s2_vld_q, s2_sign_q, s2_zero_q, s2_inf_q;
    logic [KW-1:0]   s2_k_q, s2_k_d;
    logic [CW-1:0]   s2_sh_d;
    logic [RW-1:0]   s2_rem_q, s2_rem_d;
    logic            s3_vld_q;
    posit_unpacked_t s3_q, s3_d;

    // Low bits of the two's complement only depend on low input bits.
    assign s1_mag_d = in_i[N-1] ? (~in_i[N-2:0] + (N-1)'(1)) : in_i[N-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_mag_q  <= '0;
        end else begin
            s1_vld_q <= start_i;
            if (start_i) begin
                s1_sign_q <= in_i[N-1];
                s1_zero_q <= (in_i == '0);
                s1_inf_q  <= (in_i == {1'b1, {(N-1){1'b0}}});
                s1_mag_q  <= s1_mag_d;
            end
        end
    end

    posit_lzc #(.W(N - 1), .CW(CW)) u_lzc (
        .x_i   (s1_mag_q),
        .cnt_o (lzc_cnt),
        .bit_o (lzc_bit)
    );

    // Drop regime plus terminator; a full-width regime leaves nothing behind.
    assign cnt_ext  = KW'(lzc_cnt);
    assign s2_k_d   = lzc_bit ? (cnt_ext - KW'(1)) : (KW'(0) - cnt_ext);
    assign s2_sh_d  = (lzc_cnt >= CW'(N - 2)) ? CW'(N - 1) : (lzc_cnt + CW'(1));
    assign s2_rem_d = RW'((s1_mag_q << s2_sh_d) >> (N - 1 - RW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_k_q    <= '0;
            s2_rem_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_inf_q  <= s1_inf_q;
                s2_k_q    <= s2_k_d;
                s2_rem_q  <= s2_rem_d;
            end
        end
    end

    always_comb begin
        s3_d = '0;
        if (s2_inf_q) begin
            s3_d.inf  = 1'b1;
            s3_d.sign = 1'b1;
        end else if (s2_zero_q) begin
            s3_d.zero = 1'b1;
        end else begin
            s3_d.sign  = s2_sign_q;
            s3_d.scale = {s2_k_q, s2_rem_q[RW-1 -: ES]};
            s3_d.frac  = {1'b1, s2_rem_q[RW-ES-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld_q <= 1'b0;
            s3_q     <= '0;
        end else begin
            s3_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                s3_q <= s3_d;
            end
        end
    end

`ifdef POSIT_EXTRACT_OUTREG_EN
    logic            out_vld_q;
    posit_unpacked_t out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            out_vld_q <= s3_vld_q;
            if (s3_vld_q) begin
                out_q <= s3_q;
            end
        end
    end

    assign done_o  = out_vld_q;
    assign sign_o  = out_q.sign;
    assign scale_o = out_q.scale;
    assign frac_o  = out_q.frac;
    assign zero_o  = out_q.zero;
    assign inf_o   = out_q.inf;
`else
    assign done_o  = s3_vld_q;
    assign sign_o  = s3_q.sign;
    assign scale_o = s3_q.scale;
    assign frac_o  = s3_q.frac;
    assign zero_o  = s3_q.zero;
    assign inf_o   = s3_q.inf;
`endif
endmodule

`default_nettype wire

// File: tb/tb_posit_extract.sv
// +------------------------------------------------------------------+
// | tb_posit_extract: randomized bench with bit-walking posit model. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_posit_extract;
`ifdef POSIT_EXTRACT_OUTREG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] in_i;
    logic        start_i;
    logic        sign_o;
    logic [7:0]  scale_o;
    logic [27:0] frac_o;
    logic        zero_o;
    logic        inf_o;
    logic        done_o;

    typedef struct {
        bit vld;
        bit sign;
        int scale;
        int frac;
        bit zero;
        bit inf;
    } exp_t;

    exp_t pipe_q[$];
    int   npass  = 0;
    int   ntotal = 0;

    posit_extract dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (in_i),
        .start_i (start_i),
        .sign_o  (sign_o),
        .scale_o (scale_o),
        .frac_o  (frac_o),
        .zero_o  (zero_o),
        .inf_o   (inf_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: walk the posit bit by bit from the regime onwards.
    function automatic exp_t model(input bit st, input logic [31:0] x);
        exp_t e;
        logic [31:0] v;
        int i, m, k, ex, f;
        bit r;
        e = '{default: 0};
        e.vld = st;
        if (x == 32'h0) begin
            e.zero = 1'b1;
        end else if (x == 32'h8000_0000) begin
            e.inf  = 1'b1;
            e.sign = 1'b1;
        end else begin
            e.sign = x[31];
            v = x[31] ? -x : x;
            r = v[30];
            m = 0;
            i = 30;
            while (i >= 0 && v[i] == r) begin
                m++;
                i--;
            end
            k = r ? m - 1 : -m;
            i--;
            ex = 0;
            for (int j = 0; j < 2; j++) begin
                ex = ex * 2 + ((i >= 0) ? int'(v[i]) : 0);
                i--;
            end
            f = 1;
            for (int j = 0; j < 27; j++) begin
                f = f * 2 + ((i >= 0) ? int'(v[i]) : 0);
                i--;
            end
            e.scale = k * 4 + ex;
            e.frac  = f;
        end
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"},  {31'b0, done_o}, 32'h0);
        chk({tag, "_sign"},  {31'b0, sign_o}, 32'h0);
        chk({tag, "_scale"}, {24'b0, scale_o}, 32'h0);
        chk({tag, "_frac"},  {4'b0, frac_o}, 32'h0);
        chk({tag, "_zero"},  {31'b0, zero_o}, 32'h0);
        chk({tag, "_inf"},   {31'b0, inf_o}, 32'h0);
    endtask

    task automatic flush_model();
        exp_t b;
        b = '{default: 0};
        pipe_q.delete();
        for (int n = 0; n < LAT; n++) pipe_q.push_back(b);
    endtask

    // One clock: check what should be emerging now, then launch the next operand.
    task automatic cycle(input bit st, input logic [31:0] x);
        exp_t e;
        logic [7:0] s8;
        @(negedge clk);
        e = pipe_q.pop_front();
        chk("done", {31'b0, done_o}, {31'b0, e.vld});
        if (e.vld) begin
            s8 = 8'(e.scale);
            chk("sign",  {31'b0, sign_o}, {31'b0, e.sign});
            chk("scale", {24'b0, scale_o}, {24'b0, s8});
            chk("frac",  {4'b0, frac_o}, 32'(e.frac));
            chk("zero",  {31'b0, zero_o}, {31'b0, e.zero});
            chk("inf",   {31'b0, inf_o}, {31'b0, e.inf});
        end
        start_i = st;
        in_i    = x;
        pipe_q.push_back(model(st, x));
    endtask

    task automatic drain();
        for (int n = 0; n < LAT + 1; n++) cycle(1'b0, 32'h0);
    endtask

    logic [31:0] directed [8] = '{32'hADB9_4A07, 32'h1E7C_9864, 32'h0000_0000, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h4000_0000};

    initial begin
        logic [31:0] x;
        bit          st;
        rst_n   = 1'b1;
        start_i = 1'b0;
        in_i    = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        flush_model();

        // Directed operands back to back, then a bubble, then one more.
        foreach (directed[n]) cycle(1'b1, directed[n]);
        cycle(1'b1, 32'h5A5A_1234);
        cycle(1'b0, 32'hDEAD_BEEF);
        cycle(1'b1, 32'h0123_4567);
        drain();

        // Random mix, biased toward long regimes and special encodings.
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       x = $urandom >> $urandom_range(0, 31);
                1:       x = ~($urandom >> $urandom_range(0, 31));
                2:       x = {1'b0, ~31'($urandom >> $urandom_range(0, 31))};
                3:       x = directed[$urandom_range(0, 7)];
                default: x = $urandom;
            endcase
            cycle(st, x);
        end
        drain();

        // Reset with two operands in flight: they must never appear.
        cycle(1'b1, 32'h3C3C_0F0F);
        cycle(1'b1, 32'hC000_0001);
        @(negedge clk);
        start_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        flush_model();
        for (int n = 0; n < LAT + 2; n++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h1E7C_9864);
        drain();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

`default_nettype wire
